// File: rtl/vram_write_scheduler_if.sv
`timescale 1ns/1ps
// Bus bundle for the text-RAM write scheduler: fill control, screen-ROM port,
// four single-cell requesters and the text-RAM write port.
interface vram_write_scheduler_if #(
    parameter int AW = 12
);
    logic            tick;
    logic            fill_start;
    logic            fill_src;
    logic [7:0]      fill_char;
    logic [AW-1:0]   rom_addr;
    logic [7:0]      rom_data;
    logic [3:0]      req;
    logic [4*AW-1:0] req_addr;
    logic [31:0]     req_data;
    logic [3:0]      gnt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [7:0]      wr_data;
    logic            fill_busy;
    logic            fill_done;
    logic            addr_err;

    modport master (
        output tick, fill_start, fill_src, fill_char, rom_data,
               req, req_addr, req_data,
        input  rom_addr, gnt, wr_en, wr_addr, wr_data,
               fill_busy, fill_done, addr_err
    );

    modport slave (
        input  tick, fill_start, fill_src, fill_char, rom_data,
               req, req_addr, req_data,
        output rom_addr, gnt, wr_en, wr_addr, wr_data,
               fill_busy, fill_done, addr_err
    );
endinterface

// File: rtl/vram_write_scheduler.sv
`timescale 1ns/1ps
// Text-RAM write scheduler: full-screen fill (constant or ROM copy) takes
// priority; otherwise four requesters share the write slots round-robin.
module vram_write_scheduler #(
    parameter int CELLS = 2100,
    parameter int AW    = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vram_write_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL_PRE, FILL_RUN} state_t;

    // Counter is one bit wider so it can reach CELLS after the last write.
    localparam logic [AW:0] CELLS_W = (AW+1)'(CELLS);
    localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [AW:0]   cnt, cnt_nxt;
    logic          src, src_nxt;
    logic [7:0]    chr, chr_nxt;
    logic          rom_vld, rom_vld_nxt;
    logic [1:0]    last_gnt, last_gnt_nxt;

    logic [3:0]    gnt_r, gnt_nxt;
    logic          wr_en_r, wr_en_nxt;
    logic [AW-1:0] wr_addr_r, wr_addr_nxt;
    logic [7:0]    wr_data_r, wr_data_nxt;
    logic          fill_busy_r, fill_busy_nxt;
    logic          fill_done_r, fill_done_nxt;
    logic          addr_err_r, addr_err_nxt;
    logic [AW-1:0] rom_addr_r, rom_addr_nxt;

    logic          found;
    logic [1:0]    sel, cand;
    logic [AW-1:0] sel_addr;
    logic [7:0]    sel_data;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        src_nxt       = src;
        chr_nxt       = chr;
        rom_vld_nxt   = rom_vld;
        last_gnt_nxt  = last_gnt;
        gnt_nxt       = 4'b0000;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr_r;
        wr_data_nxt   = wr_data_r;
        fill_busy_nxt = fill_busy_r;
        fill_done_nxt = 1'b0;
        addr_err_nxt  = 1'b0;
        rom_addr_nxt  = rom_addr_r;
        found         = 1'b0;
        sel           = 2'd0;
        cand          = 2'd0;

        // Round-robin search starting just after the previous winner.
        for (int k = 1; k <= 4; k++) begin
            cand = last_gnt + 2'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sel_addr = bus.req_addr[int'(sel)*AW +: AW];
        sel_data = bus.req_data[int'(sel)*8 +: 8];

        case (state)
            IDLE: begin
                if (bus.fill_start) begin
                    state_nxt     = FILL_PRE;
                    cnt_nxt       = '0;
                    src_nxt       = bus.fill_src;
                    chr_nxt       = bus.fill_char;
                    rom_vld_nxt   = 1'b0;
                    fill_busy_nxt = 1'b1;
                    rom_addr_nxt  = '0;
                end else if (bus.tick && found) begin
                    gnt_nxt[sel] = 1'b1;
                    last_gnt_nxt = sel;
                    if ({1'b0, sel_addr} >= CELLS_W) begin
                        addr_err_nxt = 1'b1;
                    end else begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = sel_addr;
                        wr_data_nxt = sel_data;
                    end
                end
            end
            FILL_PRE: begin
                // rom_addr=0 is on the bus now, so ROM data is valid next cycle.
                state_nxt   = FILL_RUN;
                rom_vld_nxt = 1'b1;
            end
            FILL_RUN: begin
                if (cnt == CELLS_W) begin
                    state_nxt     = IDLE;
                    fill_busy_nxt = 1'b0;
                    fill_done_nxt = 1'b1;
                end else if (!rom_vld) begin
                    rom_vld_nxt = 1'b1;
                end else if (bus.tick) begin
                    wr_en_nxt    = 1'b1;
                    wr_addr_nxt  = cnt[AW-1:0];
                    wr_data_nxt  = src ? bus.rom_data : chr;
                    cnt_nxt      = cnt + ONE_W;
                    rom_addr_nxt = cnt_nxt[AW-1:0];
                    rom_vld_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            src         <= 1'b0;
            chr         <= 8'h00;
            rom_vld     <= 1'b0;
            last_gnt    <= 2'd3;
            gnt_r       <= 4'b0000;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 8'h00;
            fill_busy_r <= 1'b0;
            fill_done_r <= 1'b0;
            addr_err_r  <= 1'b0;
            rom_addr_r  <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            src         <= src_nxt;
            chr         <= chr_nxt;
            rom_vld     <= rom_vld_nxt;
            last_gnt    <= last_gnt_nxt;
            gnt_r       <= gnt_nxt;
            wr_en_r     <= wr_en_nxt;
            wr_addr_r   <= wr_addr_nxt;
            wr_data_r   <= wr_data_nxt;
            fill_busy_r <= fill_busy_nxt;
            fill_done_r <= fill_done_nxt;
            addr_err_r  <= addr_err_nxt;
            rom_addr_r  <= rom_addr_nxt;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.fill_busy = fill_busy_r;
    assign bus.fill_done = fill_done_r;
    assign bus.addr_err  = addr_err_r;
    assign bus.rom_addr  = rom_addr_r;
endmodule

// File: tb/tb_vram_write_scheduler.sv
`timescale 1ns/1ps
// Bench for vram_write_scheduler: directed vector table, randomized requester
// traffic against a reference model, and full fill / abort sequences.
module tb_vram_write_scheduler;
    localparam int AW    = 12;
    localparam int CELLS = 2100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vram_write_scheduler_if #(.AW(AW)) bus ();

    vram_write_scheduler #(.CELLS(CELLS), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Screen ROM: one-cycle read latency, content = addr[7:0] + 1.
    always @(posedge clk) bus.rom_data <= bus.rom_addr[7:0] + 8'd1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic default_reqs();
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(100*i + 7);
            bus.req_data[i*8 +: 8]   = 8'h30 + 8'(i);
        end
    endtask

    typedef struct {
        logic          tick;
        logic [3:0]    req;
        logic [AW-1:0] a1;
        logic [3:0]    gnt;
        logic          wr_en;
        logic          err;
    } vec_t;

    vec_t tbl [12];

    // Full fill with optional random tick gaps and optional requester 2 held.
    task automatic do_fill(input bit src, input logic [7:0] chr, input bit rand_tick, input bit hold_req);
        int nw, bad, gnt_seen, busy_drop, cyc;
        bit done;
        logic [7:0] exp_d;
        default_reqs();
        bus.req = 4'b0000;
        if (hold_req) begin
            bus.req_addr[2*AW +: AW] = AW'(61);
            bus.req_data[2*8 +: 8]   = 8'h53;
            bus.req = 4'b0100;
        end
        bus.fill_src = src;
        bus.fill_char = chr;
        bus.fill_start = 1'b1;
        bus.tick = 1'b1;
        step();
        bus.fill_start = 1'b0;
        bus.fill_char = ~chr;
        bus.fill_src = ~src;
        check("fill_start_busy", bus.fill_busy, 1);
        check("fill_start_no_gnt", {bus.gnt, bus.wr_en}, 0);
        check("fill_pre_rom_addr", bus.rom_addr, 0);
        nw = 0; bad = 0; gnt_seen = 0; busy_drop = 0; cyc = 0; done = 0;
        while (!done && cyc < 20000) begin
            bus.tick = rand_tick ? (($urandom % 3) != 0) : 1'b1;
            step();
            cyc++;
            if (bus.gnt != 4'b0000) gnt_seen++;
            if (bus.wr_en) begin
                exp_d = src ? 8'(nw + 1) : chr;
                if (bus.wr_addr != AW'(nw) || bus.wr_data != exp_d) begin
                    if (bad == 0)
                        $display("first bad fill write %0d: addr=%0d data=%0h", nw, bus.wr_addr, bus.wr_data);
                    bad++;
                end
                nw++;
            end
            if (bus.fill_done) done = 1;
            else if (!bus.fill_busy) busy_drop++;
        end
        check("fill_done_seen", done, 1);
        check("fill_write_count", nw, CELLS);
        check("fill_write_errors", bad, 0);
        check("fill_gnt_during", gnt_seen, 0);
        check("fill_busy_dropout", busy_drop, 0);
        check("fill_busy_fall", bus.fill_busy, 0);
        bus.tick = 1'b1;
        step();
        check("fill_done_pulse", bus.fill_done, 0);
        check("post_fill_gnt", bus.gnt, hold_req ? 4'b0100 : 4'b0000);
        if (hold_req)
            check("post_fill_write", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, AW'(61), 8'h53});
        bus.req = 4'b0000;
        default_reqs();
        step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int idx, last_m, pick, cyc;
        int ra [4];
        logic [7:0] rd [4];
        logic [3:0] e_gnt;
        logic e_wr, e_err, seen;
        logic [AW+7:0] e_ad, a_ad;
        int stray;

        tbl[0]  = '{1'b1, 4'b1111, AW'(107),  4'b0001, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, AW'(107),  4'b0010, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 4'b1111, AW'(107),  4'b0100, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'b1111, AW'(107),  4'b1000, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'b1111, AW'(107),  4'b0001, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'b1111, AW'(107),  4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'b0000, AW'(107),  4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'b1001, AW'(107),  4'b1000, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 4'b0101, AW'(107),  4'b0001, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'b0010, AW'(2100), 4'b0010, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 4'b0010, AW'(2099), 4'b0010, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 4'b0110, AW'(107),  4'b0100, 1'b1, 1'b0};

        // Reset with busy-looking inputs must still leave everything quiet.
        bus.tick = 1'b1;
        bus.req = 4'b1111;
        bus.fill_start = 1'b0;
        bus.fill_src = 1'b0;
        bus.fill_char = 8'h00;
        default_reqs();
        reset_n = 1'b0;
        step();
        step();
        check("reset_outputs",
              {bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data, bus.fill_busy, bus.fill_done, bus.addr_err, bus.rom_addr},
              0);
        reset_n = 1'b1;

        for (int r = 0; r < 12; r++) begin
            bus.tick = tbl[r].tick;
            bus.req  = tbl[r].req;
            bus.req_addr[1*AW +: AW] = tbl[r].a1;
            step();
            check($sformatf("vec%0d_gnt", r), bus.gnt, tbl[r].gnt);
            check($sformatf("vec%0d_wr_en", r), bus.wr_en, tbl[r].wr_en);
            check($sformatf("vec%0d_addr_err", r), bus.addr_err, tbl[r].err);
            if (tbl[r].wr_en) begin
                idx = 0;
                for (int b = 0; b < 4; b++) if (tbl[r].gnt[b]) idx = b;
                check($sformatf("vec%0d_wr_addr", r), bus.wr_addr, (idx == 1) ? tbl[r].a1 : AW'(100*idx + 7));
                check($sformatf("vec%0d_wr_data", r), bus.wr_data, 8'h30 + 8'(idx));
            end
        end

        // Randomized requester traffic against a round-robin reference model.
        bus.req = 4'b0000;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        last_m = 3;
        for (int n = 0; n < 300; n++) begin
            bus.tick = (($urandom % 4) != 0);
            bus.req  = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                ra[i] = $urandom_range(0, CELLS + 99);
                rd[i] = 8'($urandom);
                bus.req_addr[i*AW +: AW] = AW'(ra[i]);
                bus.req_data[i*8 +: 8]   = rd[i];
            end
            step();
            e_gnt = 4'b0000; e_wr = 1'b0; e_err = 1'b0; e_ad = '0;
            if (bus.tick && bus.req != 4'b0000) begin
                pick = -1;
                for (int k = 1; k <= 4 && pick < 0; k++)
                    if (bus.req[(last_m + k) % 4]) pick = (last_m + k) % 4;
                e_gnt = 4'(1 << pick);
                if (ra[pick] >= CELLS) e_err = 1'b1;
                else begin
                    e_wr = 1'b1;
                    e_ad = {AW'(ra[pick]), rd[pick]};
                end
                last_m = pick;
            end
            a_ad = e_wr ? {bus.wr_addr, bus.wr_data} : '0;
            check($sformatf("rand%0d", n), {bus.gnt, bus.wr_en, bus.addr_err, a_ad}, {e_gnt, e_wr, e_err, e_ad});
        end
        bus.req = 4'b0000;
        step();

        do_fill(1'b0, 8'h00, 1'b0, 1'b0);
        do_fill(1'b1, 8'hC3, 1'b1, 1'b0);
        do_fill(1'b0, 8'h7E, 1'b0, 1'b1);

        // Abort a fill at cell 500 with reset, then confirm a clean restart.
        bus.fill_src = 1'b0;
        bus.fill_char = 8'h5A;
        bus.fill_start = 1'b1;
        bus.tick = 1'b1;
        step();
        bus.fill_start = 1'b0;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 5000) begin
            step();
            cyc++;
            if (bus.wr_en && bus.wr_addr == AW'(500)) seen = 1'b1;
        end
        check("abort_reached_500", seen, 1);
        reset_n = 1'b0;
        step();
        check("abort_reset_outputs",
              {bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data, bus.fill_done, bus.addr_err, bus.rom_addr}, 0);
        check("abort_fill_busy", bus.fill_busy, 0);
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.wr_en || bus.fill_done || bus.fill_busy) stray++;
        end
        check("abort_no_resume", stray, 0);
        bus.req = 4'b1111;
        step();
        check("abort_rr_reset", bus.gnt, 4'b0001);
        bus.req = 4'b0000;
        step();
        do_fill(1'b0, 8'h11, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vram_write_scheduler.md
VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

Interface
REQ-001 The block SHALL have parameter CELLS, default 2100, meaning the number of character cells in the text RAM (70 x 30).
REQ-002 The block SHALL have parameter AW, default 12, meaning the text-RAM address width.
REQ-003 The block SHALL have port clk  in  1  as the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n  in  1  as the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port tick  in  1  as the write-slot strobe; at most one RAM write is issued per tick-high cycle.
REQ-006 The block SHALL have port fill_start  in  1  as a one-cycle request to start a full-screen fill.
REQ-007 The block SHALL have port fill_src  in  1  selecting the fill source: 0 = constant fill_char, 1 = ROM copy.
REQ-008 The block SHALL have port fill_char  in  8  as the constant fill value, sampled on fill_start.
REQ-009 The block SHALL have port rom_addr  out  AW  as the screen-ROM read address.
REQ-010 The block SHALL have port rom_data  in  8  as the ROM data, valid 1 cycle after rom_addr.
REQ-011 The block SHALL have port req[3:0]  in  4  as the per-requester single-cell write requests, held until granted.
REQ-012 The block SHALL have port req_addr  in  4xAW  as the packed per-requester cell addresses (requester i at bits [i*AW +: AW]).
REQ-013 The block SHALL have port req_data  in  4x8  as the packed per-requester character codes.
REQ-014 The block SHALL have port gnt[3:0]  out  4  as a one-hot, one-cycle grant pulse.
REQ-015 The block SHALL have port wr_en  out  1  as the text-RAM write enable (one-cycle pulse).
REQ-016 The block SHALL have port wr_addr  out  AW  as the text-RAM write address.
REQ-017 The block SHALL have port wr_data  out  8  as the text-RAM write data.
REQ-018 The block SHALL have port fill_busy  out  1, high while a fill is in progress.
REQ-019 The block SHALL have port fill_done  out  1, a one-cycle pulse after the last fill write.
REQ-020 The block SHALL have port addr_err  out  1, a one-cycle pulse when a granted address is >= CELLS.

Function
REQ-021 The block SHALL implement the states IDLE, FILL_PRE and FILL_RUN.
REQ-022 All outputs SHALL be registered.
REQ-023 In IDLE, fill_start=1 SHALL clear the fill counter, latch fill_src and fill_char, and move to FILL_PRE next cycle with fill_busy=1.
REQ-024 FILL_PRE SHALL last exactly one cycle, drive rom_addr=0, and then enter FILL_RUN.
REQ-025 In FILL_RUN, rom_addr SHALL equal the fill counter, and a data-valid flag SHALL be set one cycle after every counter change.
REQ-026 In FILL_RUN, on a tick-high cycle with data valid, the block SHALL write cell=counter with data=fill_char (src 0) or rom_data (src 1) on the next cycle, and SHALL then increment the counter.
REQ-027 A tick arriving while data is invalid SHALL be skipped without a write.
REQ-028 After the write of cell CELLS-1, the block SHALL pulse fill_done together with fill_busy falling and return to IDLE.
REQ-029 While the block is not in IDLE, all req inputs SHALL be ignored with no gnt, and fill_start SHALL be ignored.
REQ-030 fill_start and any req in the same IDLE cycle SHALL be resolved in favour of the fill, with no grant issued.
REQ-031 In IDLE, a tick-high cycle with any req set SHALL grant exactly one requester by round-robin, searching from last_grant+1 upward and wrapping modulo 4.
REQ-032 On a grant, the cycle after the tick SHALL carry gnt[i]=1, wr_en=1, wr_addr=req_addr[i] and wr_data=req_data[i], and last_grant SHALL be updated to i.
REQ-033 For a granted req_addr >= CELLS, the block SHALL still pulse gnt, hold wr_en=0, and pulse addr_err.
REQ-034 With no tick, or with no req, in IDLE, wr_en and gnt SHALL remain 0.
REQ-035 Throughput SHALL be at most one write per tick, and latency from tick to wr_en SHALL be 1 cycle.

Reset
REQ-036 reset_n=0 at a clock edge SHALL force IDLE, wr_en=0, wr_addr=0, wr_data=0, gnt=0, fill_busy=0, fill_done=0, addr_err=0, rom_addr=0, fill counter=0 and last_grant=3, so requester 0 has first priority.
REQ-037 Reset asserted mid-fill SHALL abort the fill with no fill_done, and the next fill SHALL restart at cell 0.

Verification
REQ-038 Verification SHALL cover: tick held high, fill_start with fill_src=0 and fill_char=0x00 -> 2100 writes to addresses 0..2099 with data 0x00, then one fill_done pulse.
REQ-039 Verification SHALL cover: fill_src=1 with ROM model rom_data=addr[7:0]+1 -> each written cell carries data (addr[7:0]+1) and addresses show no duplicates or gaps.
REQ-040 Verification SHALL cover: req=4'b1111 held with tick every cycle -> grants in the order 0,1,2,3,0, one per cycle, each with the matching addr and data.
REQ-041 Verification SHALL cover: req[2] at addr 61 with data 0x53, plus fill_start in the same cycle -> fill wins, gnt[2] stays low until fill_done, then gnt[2] arrives with a write of 0x53 at address 61.
REQ-042 Verification SHALL cover: req[1] with addr 2100 -> gnt[1]=1, addr_err=1, wr_en=0.
REQ-043 Verification SHALL cover: reset_n=0 at fill cell 500 -> outputs return to their reset values and fill_busy=0; a new fill then starts its writes at cell 0.
